// File: rtl/cam_reset_sequencer.sv
// cam_reset_sequencer
// Camera power-up / re-initialisation sequencer in the pixclk domain.
// Walks PWDN -> RESET -> SETTLE -> START -> WAIT_DONE -> READY, holding the
// internal pipeline reset (temp_reset) until the SCCB loader reports done.
// A debounced button press restarts the whole sequence.
// Optional build macro: CAM_SEQ_WATCHDOG_EN adds a VSYNC frame watchdog that
// restarts the sequence when no VSYNC rising edge is seen for WDOG_CYCLES
// cycles while ready.
module cam_reset_sequencer #(
    parameter int PWDN_CYCLES     = 2000,
    parameter int RESET_CYCLES    = 5000,
    parameter int SETTLE_CYCLES   = 20000,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int WDOG_CYCLES     = 4000000,
    parameter int CNT_W           = 24
) (
    input  logic       pixclk,
    input  logic       rst,
    input  logic       btn_n,
    input  logic       init_done,
    input  logic       vsync,
    output logic       cam_pwdn,
    output logic       cam_rst_n,
    output logic       temp_reset,
    output logic       init_start,
    output logic       ready,
    output logic [7:0] restart_cnt
);

    typedef enum logic [2:0] {
        S_PWDN,
        S_RESET,
        S_SETTLE,
        S_START,
        S_WAIT_DONE,
        S_READY
    } state_t;

    // Timed states load N-1 on entry and leave when the counter reads 0.
    localparam logic [CNT_W-1:0] PWDN_LOAD   = CNT_W'(PWDN_CYCLES - 1);
    localparam logic [CNT_W-1:0] RESET_LOAD  = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);
    localparam logic [CNT_W-1:0] DEB_LOAD    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    state_t           state_reg, state_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;

    logic             btn_sync1_reg, btn_sync2_reg;
    logic             btn_level_reg;
    logic [CNT_W-1:0] deb_cnt_reg;
    logic             btn_fall_reg;

    logic             restart_req;
    logic [7:0]       restart_cnt_reg;

    logic cam_pwdn_reg, cam_rst_n_reg, temp_reset_reg, init_start_reg, ready_reg;
    logic cam_pwdn_next, cam_rst_n_next, temp_reset_next, init_start_next, ready_next;

    // Button synchroniser plus stability counter; a debounced falling edge
    // becomes a one-cycle registered restart request.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            btn_sync1_reg <= 1'b1;
            btn_sync2_reg <= 1'b1;
            btn_level_reg <= 1'b1;
            deb_cnt_reg   <= '0;
            btn_fall_reg  <= 1'b0;
        end else begin
            btn_sync1_reg <= btn_n;
            btn_sync2_reg <= btn_sync1_reg;
            btn_fall_reg  <= 1'b0;
            if (btn_sync2_reg == btn_level_reg) begin
                deb_cnt_reg <= DEB_LOAD;
            end else if (deb_cnt_reg == '0) begin
                btn_level_reg <= btn_sync2_reg;
                deb_cnt_reg   <= DEB_LOAD;
                btn_fall_reg  <= ~btn_sync2_reg;
            end else begin
                deb_cnt_reg <= deb_cnt_reg - CNT_ONE;
            end
        end
    end

`ifdef CAM_SEQ_WATCHDOG_EN
    localparam logic [CNT_W-1:0] WDOG_LOAD = CNT_W'(WDOG_CYCLES - 1);

    logic             vsync_d_reg;
    logic [CNT_W-1:0] wdog_cnt_reg;
    logic             wdog_expire;

    // Frame watchdog: counts READY cycles since the last VSYNC rising edge.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            vsync_d_reg  <= 1'b0;
            wdog_cnt_reg <= '0;
        end else begin
            vsync_d_reg <= vsync;
            if (state_reg != S_READY || (vsync && !vsync_d_reg)) begin
                wdog_cnt_reg <= '0;
            end else begin
                wdog_cnt_reg <= wdog_cnt_reg + CNT_ONE;
            end
        end
    end

    assign wdog_expire = (state_reg == S_READY) && (wdog_cnt_reg == WDOG_LOAD);
    assign restart_req = btn_fall_reg | wdog_expire;
`else
    logic unused_vsync;
    assign unused_vsync = vsync;
    assign restart_req  = btn_fall_reg;
`endif

    // State, delay counter, restart counter and registered outputs.
    always_ff @(posedge pixclk) begin
        if (rst) begin
            state_reg       <= S_PWDN;
            cnt_reg         <= PWDN_LOAD;
            restart_cnt_reg <= 8'd0;
            cam_pwdn_reg    <= 1'b1;
            cam_rst_n_reg   <= 1'b0;
            temp_reset_reg  <= 1'b1;
            init_start_reg  <= 1'b0;
            ready_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            cam_pwdn_reg   <= cam_pwdn_next;
            cam_rst_n_reg  <= cam_rst_n_next;
            temp_reset_reg <= temp_reset_next;
            init_start_reg <= init_start_next;
            ready_reg      <= ready_next;
            if (restart_req && restart_cnt_reg != 8'hFF) begin
                restart_cnt_reg <= restart_cnt_reg + 8'd1;
            end
        end
    end

    // Next-state logic; a restart request overrides every transition.
    always_comb begin
        state_next = state_reg;
        cnt_next   = (cnt_reg != '0) ? (cnt_reg - CNT_ONE) : '0;
        case (state_reg)
            S_PWDN: begin
                if (cnt_reg == '0) begin
                    state_next = S_RESET;
                    cnt_next   = RESET_LOAD;
                end
            end
            S_RESET: begin
                if (cnt_reg == '0) begin
                    state_next = S_SETTLE;
                    cnt_next   = SETTLE_LOAD;
                end
            end
            S_SETTLE: begin
                if (cnt_reg == '0) begin
                    state_next = S_START;
                end
            end
            S_START:     state_next = S_WAIT_DONE;
            S_WAIT_DONE: if (init_done) state_next = S_READY;
            S_READY:     state_next = S_READY;
            default:     state_next = S_PWDN;
        endcase
        if (restart_req) begin
            state_next = S_PWDN;
            cnt_next   = PWDN_LOAD;
        end
    end

    // Output decode of the upcoming state, captured into the output registers.
    always_comb begin
        cam_pwdn_next   = 1'b0;
        cam_rst_n_next  = 1'b1;
        temp_reset_next = 1'b1;
        init_start_next = 1'b0;
        ready_next      = 1'b0;
        case (state_next)
            S_PWDN: begin
                cam_pwdn_next  = 1'b1;
                cam_rst_n_next = 1'b0;
            end
            S_RESET:  cam_rst_n_next  = 1'b0;
            S_START:  init_start_next = 1'b1;
            S_READY: begin
                temp_reset_next = 1'b0;
                ready_next      = 1'b1;
            end
            default: ;
        endcase
    end

    assign cam_pwdn    = cam_pwdn_reg;
    assign cam_rst_n   = cam_rst_n_reg;
    assign temp_reset  = temp_reset_reg;
    assign init_start  = init_start_reg;
    assign ready       = ready_reg;
    assign restart_cnt = restart_cnt_reg;

endmodule

// File: tb/tb_cam_reset_sequencer.sv
// Testbench for cam_reset_sequencer: directed timing checks plus randomized
// stimulus compared every cycle against an elapsed-time reference model.
module tb_cam_reset_sequencer;

    localparam int P = 4;
    localparam int R = 8;
    localparam int S = 16;
    localparam int D = 3;
    localparam int W = 100;

    logic       pixclk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_n = 1'b1;
    logic       init_done = 1'b0;
    logic       vsync = 1'b0;
    logic       cam_pwdn, cam_rst_n, temp_reset, init_start, ready;
    logic [7:0] restart_cnt;

    int checks = 0;
    int failures = 0;

    // Reference model state: time since sequence start, done flag, counts.
    int m_t;
    bit m_done;
    int m_cnt;
    bit m_level;
    int m_run;
    bit m_fall;
    bit btn_q[$];
    int m_wd;
    bit m_pv;

    cam_reset_sequencer #(
        .PWDN_CYCLES(P), .RESET_CYCLES(R), .SETTLE_CYCLES(S),
        .DEBOUNCE_CYCLES(D), .WDOG_CYCLES(W), .CNT_W(24)
    ) dut (
        .pixclk(pixclk), .rst(rst), .btn_n(btn_n), .init_done(init_done),
        .vsync(vsync), .cam_pwdn(cam_pwdn), .cam_rst_n(cam_rst_n),
        .temp_reset(temp_reset), .init_start(init_start), .ready(ready),
        .restart_cnt(restart_cnt)
    );

    always #5 pixclk = ~pixclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [12:0] model_outs();
        logic pw, rn, tr, st, rd;
        if (m_done) begin
            pw = 0; rn = 1; tr = 0; st = 0; rd = 1;
        end else if (m_t < P) begin
            pw = 1; rn = 0; tr = 1; st = 0; rd = 0;
        end else if (m_t < P + R) begin
            pw = 0; rn = 0; tr = 1; st = 0; rd = 0;
        end else begin
            pw = 0; rn = 1; tr = 1; st = (m_t == P + R + S); rd = 0;
        end
        return {pw, rn, tr, st, rd, 8'(m_cnt)};
    endfunction

    // Advance the model by one clock edge using the inputs sampled there.
    task automatic model_edge();
        bit s;
        bit restart;
        if (rst) begin
            m_t = 0; m_done = 0; m_cnt = 0; m_level = 1; m_run = 0; m_fall = 0;
            btn_q = {1'b1, 1'b1}; m_wd = 0; m_pv = 0;
        end else begin
            restart = m_fall;
`ifdef CAM_SEQ_WATCHDOG_EN
            if (m_done && m_wd == W - 1) restart = 1;
            if (!m_done) m_wd = 0;
            else if (vsync && !m_pv) m_wd = 0;
            else m_wd++;
            m_pv = vsync;
`endif
            // Button seen by the debouncer is the one sampled two edges ago.
            s = btn_q.pop_front();
            btn_q.push_back(btn_n);
            m_fall = 0;
            if (s != m_level) begin
                m_run++;
                if (m_run == D) begin
                    m_level = s;
                    m_run = 0;
                    m_fall = !s;
                end
            end else begin
                m_run = 0;
            end
            if (restart) begin
                m_t = 0; m_done = 0;
                if (m_cnt < 255) m_cnt++;
            end else if (!m_done) begin
                if (m_t > P + R + S && init_done) m_done = 1;
                else if (m_t <= P + R + S) m_t++;
            end
        end
    endtask

    task automatic step();
        @(posedge pixclk);
        model_edge();
        #1;
        check_val("outs", {19'd0, cam_pwdn, cam_rst_n, temp_reset, init_start, ready, restart_cnt},
                  {19'd0, model_outs()});
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        int starts;
        int btn_hold;
        logic [12:0] rst_vec;
        rst_vec = {1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'd0};

        // Power-up timing from reset release.
        rst = 1; run(3);
        check_val("rst_hold", {19'd0, cam_pwdn, cam_rst_n, temp_reset, init_start, ready, restart_cnt}, {19'd0, rst_vec});
        rst = 0;
        for (int c = 1; c <= 33; c++) begin
            if (c == 33) init_done = 1;
            step();
            if (c == 1)  check_val("first_cycle", {19'd0, cam_pwdn, cam_rst_n, temp_reset, init_start, ready, restart_cnt}, {19'd0, rst_vec});
            if (c == 11) check_val("rst_n_c11", cam_rst_n, 0);
            if (c == 12) check_val("rst_n_c12", cam_rst_n, 1);
            if (c == 27) check_val("start_c27", init_start, 0);
            if (c == 28) check_val("start_c28", init_start, 1);
            if (c == 29) check_val("start_c29", init_start, 0);
            if (c == 32) check_val("ready_c32", ready, 0);
            if (c == 33) begin
                check_val("ready_c33", ready, 1);
                check_val("temp_c33", temp_reset, 0);
            end
        end
        init_done = 0; run(10);
        check_val("ready_hold", ready, 1);

        // Short glitch must be ignored; a long press restarts.
        btn_n = 0; run(2); btn_n = 1; run(10);
        check_val("glitch_cnt", restart_cnt, 0);
        check_val("glitch_ready", ready, 1);
        btn_n = 0;
        for (int k = 1; k <= 10; k++) begin
            step();
            if (k == 5) check_val("press_k5_pwdn", cam_pwdn, 0);
            if (k == 6) begin
                check_val("press_k6_pwdn", cam_pwdn, 1);
                check_val("press_k6_ready", ready, 0);
            end
        end
        check_val("press_cnt", restart_cnt, 1);
        btn_n = 1; run(10);

        // Press during SETTLE aborts the run before init_start.
        rst = 1; run(2); rst = 0;
        starts = 0;
        for (int c = 1; c <= 48; c++) begin
            if (c == 15) btn_n = 0;
            step();
            if (c < 48 && init_start) starts++;
            if (c == 19) check_val("settle_pre", cam_rst_n, 1);
            if (c == 20) check_val("settle_restart", cam_pwdn, 1);
            if (c == 48) check_val("settle_new_start", init_start, 1);
        end
        check_val("no_abort_start", starts, 0);
        check_val("settle_cnt", restart_cnt, 1);
        btn_n = 1; run(10);

        // Randomized stimulus against the model.
        btn_hold = 0;
        for (int i = 0; i < 3000; i++) begin
            if (btn_hold == 0) begin
                btn_n = ~btn_n;
                btn_hold = $urandom_range(1, 8);
            end else begin
                btn_hold--;
            end
            init_done = ($urandom_range(0, 9) < 3);
            rst = ($urandom_range(0, 399) == 0);
            vsync = $urandom_range(0, 1);
            step();
        end
        rst = 0; btn_n = 1; init_done = 0; vsync = 0;

        // Restart counter saturation, then reset in WAIT_DONE.
        rst = 1; run(2); rst = 0;
        for (int n = 0; n < 300; n++) begin
            btn_n = 0; run(6);
            btn_n = 1; run(6);
        end
        run(40);
        check_val("cnt_sat", restart_cnt, 255);
        check_val("wait_ready", ready, 0);
        check_val("wait_temp", temp_reset, 1);
        rst = 1; step();
        check_val("rst_vals_hold", {19'd0, cam_pwdn, cam_rst_n, temp_reset, init_start, ready, restart_cnt}, {19'd0, rst_vec});
        rst = 0; step();
        check_val("rst_vals_first", {19'd0, cam_pwdn, cam_rst_n, temp_reset, init_start, ready, restart_cnt}, {19'd0, rst_vec});

`ifdef CAM_SEQ_WATCHDOG_EN
        begin
            int n;
            // VSYNC stopped: READY lasts exactly W cycles.
            rst = 1; run(2); rst = 0; init_done = 1;
            n = 0;
            while (!ready && n < 100) begin step(); n++; end
            check_val("wd_reach_ready", ready, 1);
            n = 1;
            for (int i = 0; i < 200 && ready; i++) begin
                step();
                if (ready) n++;
            end
            check_val("wd_ready_len", n, W);
            check_val("wd_cnt", restart_cnt, 1);
            // VSYNC every 50 cycles keeps READY.
            rst = 1; run(2); rst = 0;
            run(40);
            for (int i = 0; i < 300; i++) begin
                vsync = (i % 50 == 0);
                step();
            end
            vsync = 0;
            check_val("wd_vsync_ready", ready, 1);
            init_done = 0;
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/cam_reset_sequencer.md
# cam_reset_sequencer

Camera power-up and re-initialisation sequencer in the `pixclk` domain. Drives the camera power-down and reset pins, and generates `temp_reset`, the internal reset that holds the capture/LCD pipeline and the `ek` logic during camera bring-up. Hands off to the SCCB register loader with a start pulse, then reports ready. Re-runs the full sequence on a debounced user button press or, optionally, when the frame watchdog expires.

## Interface
- `PWDN_CYCLES`, 2000: cycles `cam_pwdn` is held high.
- `RESET_CYCLES`, 5000: cycles `cam_rst_n` is held low.
- `SETTLE_CYCLES`, 20000: cycles between reset release and `init_start`.
- `DEBOUNCE_CYCLES`, 50000: cycles `btn_n` must stay stable before it is accepted.
- `WDOG_CYCLES`, 4000000: maximum number of cycles between VSYNC rising edges while ready (used only with the watchdog).
- `CNT_W`, 24: width of the shared delay counter. Every `*_CYCLES` value must be ≥1 and < 2^CNT_W.
- `pixclk` in 1: single clock.
- `rst` in 1: synchronous, active-high reset.
- `btn_n` in 1: raw asynchronous button, active low.
- `init_done` in 1: level from the SCCB loader; high when register load is complete.
- `vsync` in 1: camera VSYNC, already in the `pixclk` domain.
- `cam_pwdn` out 1: camera power-down, active high.
- `cam_rst_n` out 1: camera reset, active low.
- `temp_reset` out 1: internal pipeline reset, active high.
- `init_start` out 1: one-cycle pulse that starts the SCCB loader.
- `ready` out 1: sequence complete and camera configured.
- `restart_cnt` out 8: number of re-runs since `rst`; saturates at 255.

## Operation
- FSM states: PWDN → RESET → SETTLE → START → WAIT_DONE → READY.
- PWDN: `cam_pwdn`=1, `cam_rst_n`=0, `temp_reset`=1.
- RESET: `cam_pwdn`=0, `cam_rst_n`=0, `temp_reset`=1.
- SETTLE: `cam_rst_n`=1, `temp_reset`=1.
- START: `init_start`=1 for exactly one cycle; `temp_reset`=1.
- WAIT_DONE: `temp_reset`=1; move to READY on the first cycle `init_done`=1.
- READY: `temp_reset`=0, `ready`=1.
- Each timed state loads the counter with N−1 on entry and exits when the counter is 0, so the state lasts exactly N cycles.
- Button input: 2-FF synchroniser, then a stability counter. The debounced level changes only after the synchronised input has held a new value for `DEBOUNCE_CYCLES` consecutive cycles; any bounce reloads the counter. A falling edge of the debounced level is a restart request.
- Restart request in any state: next state is PWDN with a fresh counter; `restart_cnt` increments (saturating). A request that arrives during PWDN also restarts PWDN.
- `rst`: FSM goes to PWDN, counters clear, debounced level is set to 1, `restart_cnt` clears. A `rst` in mid-sequence abandons the sequence; it is not counted as a restart.
- If a restart request and `init_done` occur in the same cycle, the restart wins.

## Timing
- Values while `rst` is high and in the first cycle after it: `cam_pwdn`=1, `cam_rst_n`=0, `temp_reset`=1, `init_start`=0, `ready`=0, `restart_cnt`=0.
- All outputs are registered and decoded from the state register. No output has a combinational path from an input.
- `init_start` is asserted exactly PWDN_CYCLES+RESET_CYCLES+SETTLE_CYCLES cycles after `rst` is released.
- `temp_reset` falls and `ready` rises together, 1 cycle after `init_done` is sampled high in WAIT_DONE.
- Restart latency: outputs return to PWDN values 1 cycle after the debounced falling edge. That edge occurs 2+DEBOUNCE_CYCLES cycles after the raw edge.

## Configuration
- `CAM_SEQ_WATCHDOG_EN` defined: in READY, a counter clears on each `vsync` rising edge. If the count reaches WDOG_CYCLES, the block restarts exactly like a button press, including the `restart_cnt` increment. The counter is cleared outside READY.
- Not defined: watchdog logic and the `vsync` edge detector are absent. The `vsync` port remains and is ignored.

## Test plan
- Parameters PWDN=4, RESET=8, SETTLE=16, pulse `rst` → `init_start` high in exactly cycle 28 after release; `cam_rst_n` rises in cycle 12.
- `init_done` raised 5 cycles after `init_start` → `ready`=1 and `temp_reset`=0 one cycle later; values hold.
- DEBOUNCE=3: `btn_n` glitches low for 2 cycles → no restart. Then held low for 10 cycles → PWDN re-entered, `restart_cnt`=1.
- Button press during SETTLE → sequence restarts from PWDN, `init_start` is never pulsed for the aborted run.
- `CAM_SEQ_WATCHDOG_EN` with WDOG=100, `vsync` stopped in READY → restart after 100 cycles; with `vsync` every 50 cycles → `ready` stays high.
- 300 restarts → `restart_cnt`=255. A `rst` pulse in WAIT_DONE → `restart_cnt`=0 and outputs at their reset values.
